calc_controller: RTL and testbench

CALC_CONTROLLER -- requirements
Module: calc_controller

---
 rtl/calculator_pkg.sv | 17 +
 rtl/calc_result_buffer.sv | 39 +++
 rtl/calc_controller.sv | 140 ++++++++++++++
 tb/tb_calc_controller.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/calculator_pkg.sv
// Shared widths and FSM encoding for the SRAM add-pair calculator.
package calculator_pkg;

  localparam int DATA_W        = 32;
  localparam int MEM_WORD_SIZE = 64;
  localparam int ADDR_W        = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_ADD,
    S_WRITE,
    S_DONE
  } state_t;

endpackage

// File: rtl/calc_result_buffer.sv
// Packs two DATA_W results into one SRAM word: first load goes low, second high.
module calc_result_buffer #(
  parameter int DATA_W        = 32,
  parameter int MEM_WORD_SIZE = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic                     clear,
  input  logic [DATA_W-1:0]        din,
  output logic [MEM_WORD_SIZE-1:0] data,
  output logic                     full
);

  logic lo_held;

  // The load in progress completes the pair when the low half is already held.
  assign full = load && lo_held;

  // Half-select load; clear wins so a stale pair never leaks into the next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data    <= '0;
      lo_held <= 1'b0;
    end else if (clear) begin
      data    <= '0;
      lo_held <= 1'b0;
    end else if (load) begin
      if (lo_held) begin
        data[MEM_WORD_SIZE-1:DATA_W] <= din;
        lo_held                      <= 1'b0;
      end else begin
        data[DATA_W-1:0] <= din;
        lo_held          <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/calc_controller.sv
// Reads operand words {A,B}, writes packed A+B results back to SRAM.
module calc_controller #(
  parameter int DATA_W        = calculator_pkg::DATA_W,
  parameter int MEM_WORD_SIZE = calculator_pkg::MEM_WORD_SIZE,
  parameter int ADDR_W        = calculator_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        read_start_addr,
  input  logic [ADDR_W-1:0]        read_end_addr,
  input  logic [ADDR_W-1:0]        write_start_addr,
  input  logic [ADDR_W-1:0]        write_end_addr,
  output logic                     sram_rd_en,
  output logic                     sram_wr_en,
  output logic [ADDR_W-1:0]        sram_addr,
  output logic [MEM_WORD_SIZE-1:0] sram_wdata,
  input  logic [MEM_WORD_SIZE-1:0] sram_rdata,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  import calculator_pkg::*;

  state_t                   state;
  logic [ADDR_W-1:0]        rd_addr;
  logic [ADDR_W-1:0]        rd_end_q;
  // One extra bit so the write pointer can step past the top line without wrapping.
  logic [ADDR_W:0]          wr_addr;
  logic [ADDR_W-1:0]        wr_end_q;
  logic                     last_q;
  logic [MEM_WORD_SIZE-1:0] op_q;
  logic [DATA_W-1:0]        sum;
  logic                     last;
  logic                     buf_load;
  logic                     buf_clear;
  logic                     buf_full;

  assign sum       = op_q[MEM_WORD_SIZE-1:DATA_W] + op_q[DATA_W-1:0];
  assign last      = (rd_addr == rd_end_q);
  assign buf_load  = (state == S_ADD);
  assign buf_clear = (state == S_WRITE) || (state == S_IDLE);

  calc_result_buffer #(
    .DATA_W        (DATA_W),
    .MEM_WORD_SIZE (MEM_WORD_SIZE)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (buf_load),
    .clear (buf_clear),
    .din   (sum),
    .data  (sram_wdata),
    .full  (buf_full)
  );

  // Job sequencer; strobes and status are registered and set on state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      sram_rd_en <= 1'b0;
      sram_wr_en <= 1'b0;
      sram_addr  <= '0;
      rd_addr    <= '0;
      rd_end_q   <= '0;
      wr_addr    <= '0;
      wr_end_q   <= '0;
      last_q     <= 1'b0;
      op_q       <= '0;
    end else begin
      sram_rd_en <= 1'b0;
      sram_wr_en <= 1'b0;
      done       <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          err      <= 1'b0;
          rd_addr  <= read_start_addr;
          rd_end_q <= read_end_addr;
          wr_addr  <= {1'b0, write_start_addr};
          wr_end_q <= write_end_addr;
          last_q   <= 1'b0;
          if (read_end_addr < read_start_addr) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            busy       <= 1'b1;
            sram_rd_en <= 1'b1;
            sram_addr  <= read_start_addr;
            state      <= S_READ;
          end
        end
        S_READ: state <= S_WAIT;
        S_WAIT: begin
          op_q  <= sram_rdata;
          state <= S_ADD;
        end
        S_ADD: begin
          last_q <= last;
          if (!last) rd_addr <= rd_addr + ADDR_W'(1);
          if (buf_full || last) begin
            if (wr_addr > {1'b0, wr_end_q}) begin
              err   <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              sram_wr_en <= 1'b1;
              sram_addr  <= wr_addr[ADDR_W-1:0];
              state      <= S_WRITE;
            end
          end else begin
            sram_rd_en <= 1'b1;
            sram_addr  <= rd_addr + ADDR_W'(1);
            state      <= S_READ;
          end
        end
        S_WRITE: begin
          wr_addr <= wr_addr + (ADDR_W+1)'(1);
          if (!last_q) begin
            sram_rd_en <= 1'b1;
            sram_addr  <= rd_addr;
            state      <= S_READ;
          end else begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_controller.sv
// Self-checking bench: SRAM model, write scoreboard, job vector table.
module tb_calc_controller;
  import calculator_pkg::*;

  localparam int AW = ADDR_W;
  localparam int MW = MEM_WORD_SIZE;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] rs_i = '0, re_i = '0, ws_i = '0, we_i = '0;
  logic          rd_en, wr_en, busy, done, err;
  logic [AW-1:0] addr;
  logic [MW-1:0] wdata;
  logic [MW-1:0] rdata = '0;

  calc_controller dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .read_start_addr  (rs_i),
    .read_end_addr    (re_i),
    .write_start_addr (ws_i),
    .write_end_addr   (we_i),
    .sram_rd_en       (rd_en),
    .sram_wr_en       (wr_en),
    .sram_addr        (addr),
    .sram_wdata       (wdata),
    .sram_rdata       (rdata),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  always #5 clk = ~clk;

  logic [MW-1:0] mem [0:(1<<AW)-1];

  // SRAM: read data one cycle after the strobe
  always @(posedge clk) begin
    if (rd_en) rdata <= mem[addr];
    if (wr_en) mem[addr] <= wdata;
  end

  typedef struct { int a; logic [MW-1:0] d; } wr_t;
  wr_t exp_q[$];

  typedef struct { int rs, re, ws, we, err, rd, wr, lat, poke; } vec_t;
  vec_t vecs[8];

  int checks = 0, failures = 0;
  int cyc = 0, start_cyc = 0;
  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, first_rd = -1, done_cyc = -1;
  logic busy_after;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Output monitor and write scoreboard
  always @(negedge clk) if (rst_n) begin
    if (rd_en && wr_en) chk("rd_wr_same_cycle", 64'd1, 64'd0);
    if (rd_en) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (wr_en) begin
      wr_cnt++;
      if (exp_q.size() == 0) chk("unexpected_write_addr", 64'(addr), 64'hFFFF);
      else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(addr), 64'(e.a));
        chk("wr_data", wdata, e.d);
      end
    end
  end

  // Reference: sum each operand pair, pack two per word, stop on write overflow.
  task automatic model(input int rs, input int re, input int ws, input int we);
    logic [MW-1:0] word;
    logic [31:0]   r;
    int            w;
    word = '0;
    w = ws;
    for (int i = rs; i <= re; i++) begin
      r = mem[i][63:32] + mem[i][31:0];
      if (((i - rs) % 2) == 0) word[31:0] = r;
      else word[63:32] = r;
      if (((i - rs) % 2) == 1 || i == re) begin
        if (w > we) break;
        exp_q.push_back('{w, word});
        w++;
        word = '0;
      end
    end
  endtask

  task automatic run_job(input int rs, input int re, input int ws, input int we, input int poke);
    @(negedge clk);
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; first_rd = -1; done_cyc = -1;
    rs_i = AW'(rs); re_i = AW'(re); ws_i = AW'(ws); we_i = AW'(we);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    busy_after = busy;
    for (int n = 0; n < 3000 && done_cnt == 0; n++) begin
      if (n == poke) begin
        start = 1'b1; rs_i = '0; re_i = '0; ws_i = '0; we_i = '1;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    if (done_cnt == 0) chk("job_timeout", 64'd0, 64'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = {$urandom, $urandom};
    mem[0] = {32'd1, 32'd2};
    mem[1] = {32'hFFFF_FFFF, 32'd1};
    mem[2] = {32'd5, 32'd5};
    mem[3] = {32'd7, 32'd0};

    //            rs   re   ws   we  err  rd  wr  lat poke
    vecs[0] = '{  0,   3, 100, 101,  0,  4,  2,  14,  -1};
    vecs[1] = '{ 10,  12,  20,  25,  0,  3,  2,  11,   4};
    vecs[2] = '{  5,   4,  90,  95,  1,  0,  0,  -1,  -1};
    vecs[3] = '{ 30,  33,  50,  50,  1,  4,  1,  -1,  -1};
    vecs[4] = '{200, 210, 300, 320,  0, 11,  6,  39,  -1};
    vecs[5] = '{505, 511, 400, 511,  0,  7,  4,  25,  -1};
    vecs[6] = '{ 60,  60, 510, 511,  0,  1,  1,   4,  -1};
    vecs[7] = '{ 70,  72, 511, 511,  1,  3,  1,  -1,  -1};

    #12;
    chk("reset_ctrl", 64'({busy, done, err, rd_en, wr_en}), 64'd0);
    chk("reset_addr", 64'(addr), 64'd0);
    chk("reset_wdata", wdata, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      model(vecs[k].rs, vecs[k].re, vecs[k].ws, vecs[k].we);
      run_job(vecs[k].rs, vecs[k].re, vecs[k].ws, vecs[k].we, vecs[k].poke);
      chk($sformatf("v%0d_err", k), 64'(err), 64'(vecs[k].err));
      chk($sformatf("v%0d_reads", k), 64'(rd_cnt), 64'(vecs[k].rd));
      chk($sformatf("v%0d_writes", k), 64'(wr_cnt), 64'(vecs[k].wr));
      chk($sformatf("v%0d_done_pulses", k), 64'(done_cnt), 64'd1);
      chk($sformatf("v%0d_busy", k), 64'(busy_after), 64'(vecs[k].rd != 0));
      chk($sformatf("v%0d_pending", k), 64'(exp_q.size()), 64'd0);
      if (vecs[k].lat >= 0)
        chk($sformatf("v%0d_latency", k), 64'(done_cyc - first_rd), 64'(vecs[k].lat));
      if (vecs[k].rd == 0)
        chk($sformatf("v%0d_done_next", k), 64'(done_cyc - start_cyc), 64'd1);
    end

    chk("mem100", mem[100], 64'h0000_0000_0000_0003);
    chk("mem101", mem[101], 64'h0000_0007_0000_000A);

    // Reset during the WAIT of the second read
    @(negedge clk);
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; first_rd = -1;
    rs_i = AW'(0); re_i = AW'(3); ws_i = AW'(100); we_i = AW'(101);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 50 && rd_cnt < 2; n++) @(negedge clk);
    if (rd_cnt < 2) chk("second_read_timeout", 64'(rd_cnt), 64'd2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midjob_reset_ctrl", 64'({busy, done, err, rd_en, wr_en}), 64'd0);
    chk("midjob_reset_addr", 64'(addr), 64'd0);
    chk("midjob_reset_wdata", wdata, 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rd_cnt = 0; wr_cnt = 0;
    repeat (6) @(negedge clk);
    chk("strobes_after_reset", 64'(rd_cnt + wr_cnt), 64'd0);

    model(0, 3, 100, 101);
    run_job(0, 3, 100, 101, -1);
    chk("rerun_err", 64'(err), 64'd0);
    chk("rerun_writes", 64'(wr_cnt), 64'd2);
    chk("rerun_latency", 64'(done_cyc - first_rd), 64'd14);
    chk("rerun_pending", 64'(exp_q.size()), 64'd0);
    chk("rerun_mem101", mem[101], 64'h0000_0007_0000_000A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
